online_div_sequencer: RTL and testbench

- Top-level sequencer for the digit-serial on-line divider datapath.
- Accepts dividend (x) and divisor (d) radix-2 signed digits from an upstream source over a valid/ready handshake.
- Feeds the digits to the divider at its digit-period rate, honours the on-line delay DELTA, and feeds zeros during flush.
- Collects the N_DIGITS quotient digits, presents them downstream, and reports done/error.

---
 rtl/online_div_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_online_div_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/online_div_sequencer.sv
// rtl/online_div_sequencer.sv - digit-serial on-line divider sequencer
// Optional stall counter output enabled by ONLINE_DIV_STALL_CNT_EN.
module online_div_sequencer #(
    parameter int N_DIGITS      = 8,
    parameter int DELTA         = 3,
    parameter int CYC_PER_DIGIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] x_in,
    input  logic [1:0] d_in,
    output logic [1:0] div_x_value,
    output logic [1:0] div_d_value,
    output logic       div_step,
    input  logic [1:0] div_q_value,
    input  logic       div_error_flag,
    output logic       q_valid,
    output logic [1:0] q_out,
    output logic       q_last,
    output logic       busy,
    output logic       done,
    output logic       err
`ifdef ONLINE_DIV_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [7:0] N_L      = 8'(N_DIGITS);
    localparam logic [7:0] D_L      = 8'(DELTA);
    localparam logic [3:0] CYC_LAST = 4'(CYC_PER_DIGIT - 1);

    logic [2:0] state_q, state_d;
    logic [3:0] cyc_q, cyc_d;
    logic [7:0] in_cnt_q, in_cnt_d;
    logic [7:0] per_q, per_d;
    logic [7:0] q_cnt_q, q_cnt_d;
    logic [1:0] x_q, x_d, d_q, d_d, q_out_q, q_out_d;
    logic       q_valid_q, q_valid_d, q_last_q, q_last_d, err_q, err_d;
    logic       active, in_slot, accept, step, capture;

    // The reserved code 2'b11 is not a legal digit; the divider sees it as zero.
    function automatic logic [1:0] sanitize(input logic [1:0] v);
        return (v == 2'b11) ? 2'b00 : v;
    endfunction

    assign active  = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_FLUSH);
    assign in_slot = ((state_q == S_LOAD) || (state_q == S_RUN)) &&
                     (cyc_q == 4'd0) && (in_cnt_q < N_L);
    assign accept  = in_slot && in_valid;
    assign step    = active && (cyc_q == CYC_LAST);
    assign capture = step && (per_q >= D_L);

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        in_cnt_d  = in_cnt_q;
        per_d     = per_q;
        q_cnt_d   = q_cnt_q;
        x_d       = x_q;
        d_d       = d_q;
        err_d     = err_q;
        q_out_d   = q_out_q;
        q_valid_d = 1'b0;
        q_last_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cyc_d    = '0;
                in_cnt_d = '0;
                per_d    = '0;
                q_cnt_d  = '0;
                x_d      = '0;
                d_d      = '0;
                if (start) begin
                    state_d = S_LOAD;
                    err_d   = 1'b0;
                end
            end
            S_LOAD, S_RUN, S_FLUSH: begin
                if (accept) begin
                    x_d      = sanitize(x_in);
                    d_d      = sanitize(d_in);
                    in_cnt_d = in_cnt_q + 8'd1;
                    cyc_d    = 4'd1;
                end else if (!in_slot) begin
                    cyc_d = step ? 4'd0 : cyc_q + 4'd1;
                end
                if (step) begin
                    per_d = per_q + 8'd1;
                    if (capture) begin
                        q_valid_d = 1'b1;
                        q_out_d   = div_q_value;
                        q_last_d  = (q_cnt_q == N_L - 8'd1);
                        q_cnt_d   = q_cnt_q + 8'd1;
                    end
                    if (state_q == S_LOAD && per_q == D_L - 8'd1) begin
                        state_d = S_RUN;
                    end
                    if (state_q == S_RUN && in_cnt_q == N_L) begin
                        state_d = S_FLUSH;
                        x_d     = '0;
                        d_d     = '0;
                    end
                end
                if (state_q == S_FLUSH && q_cnt_q == N_L) begin
                    state_d = S_DONE;
                end
                // A capture on the error cycle is still emitted; later ones never happen.
                if (div_error_flag) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cyc_q     <= '0;
            in_cnt_q  <= '0;
            per_q     <= '0;
            q_cnt_q   <= '0;
            x_q       <= '0;
            d_q       <= '0;
            err_q     <= 1'b0;
            q_out_q   <= '0;
            q_valid_q <= 1'b0;
            q_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            in_cnt_q  <= in_cnt_d;
            per_q     <= per_d;
            q_cnt_q   <= q_cnt_d;
            x_q       <= x_d;
            d_q       <= d_d;
            err_q     <= err_d;
            q_out_q   <= q_out_d;
            q_valid_q <= q_valid_d;
            q_last_q  <= q_last_d;
        end
    end

`ifdef ONLINE_DIV_STALL_CNT_EN
    logic        stall;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    assign stall = in_slot && !in_valid;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == S_IDLE && start) begin
            stall_cnt_d = '0;
        end else if (stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign in_ready    = in_slot;
    assign div_x_value = x_q;
    assign div_d_value = d_q;
    assign div_step    = step;
    assign q_valid     = q_valid_q;
    assign q_out       = q_out_q;
    assign q_last      = q_last_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign err         = err_q;

endmodule

// File: tb/tb_online_div_sequencer.sv
// tb/tb_online_div_sequencer.sv - randomized self-checking bench for online_div_sequencer
module tb_online_div_sequencer;
    localparam int N   = 8;
    localparam int DL  = 3;
    localparam int CPD = 4;
    localparam int NS  = N + DL;

    logic       clk = 1'b0;
    logic       rst_n, start, in_valid, in_ready, div_step, div_error_flag;
    logic       q_valid, q_last, busy, done, err;
    logic [1:0] x_in, d_in, div_x_value, div_d_value, div_q_value, q_out;
`ifdef ONLINE_DIV_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    online_div_sequencer #(.N_DIGITS(N), .DELTA(DL), .CYC_PER_DIGIT(CPD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .d_in(d_in), .div_x_value(div_x_value), .div_d_value(div_d_value),
        .div_step(div_step), .div_q_value(div_q_value), .div_error_flag(div_error_flag),
        .q_valid(q_valid), .q_out(q_out), .q_last(q_last), .busy(busy), .done(done), .err(err)
`ifdef ONLINE_DIV_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [1:0] xs [N];
    logic [1:0] ds [N];
    logic [1:0] qpat [16];
    int         step_t [$];
    logic [1:0] step_x [$];
    logic [1:0] step_d [$];
    int         qv_t [$];
    logic [1:0] qv_q [$];
    logic       qv_l [$];
    int         n_done, done_at, err_first, ir_bad;
    logic       err0, last_busy;

    function automatic logic [1:0] fwd(input logic [1:0] v);
        return (v == 2'b11) ? 2'b00 : v;
    endfunction

    // Cycle (relative to the first LOAD cycle) of the k-th step, stall of len cycles before digit a.
    function automatic int exp_step(input int k, input int a, input int len);
        return CPD * k - 1 + ((len > 0 && k >= a + 1) ? len : 0);
    endfunction

    function automatic logic [1:0] exp_x(input int k);
        return (k <= N) ? fwd(xs[k-1]) : 2'b00;
    endfunction

    function automatic logic [1:0] exp_d(input int k);
        return (k <= N) ? fwd(ds[k-1]) : 2'b00;
    endfunction

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            xs[i] = 2'($urandom_range(0, 3));
            ds[i] = 2'($urandom_range(0, 3));
        end
        for (int i = 0; i < 16; i++) begin
            int v = $urandom_range(0, 2);
            qpat[i] = (v == 0) ? 2'b00 : (v == 1) ? 2'b01 : 2'b10;
        end
    endtask

    // Upstream source, divider model and event recorder; t counts cycles from LOAD entry.
    task automatic run_op(input int stall_at, input int stall_len, input int err_rel,
                          input int busy_rel, input int stop_at);
        int idx = 0;
        int sl = stall_len;
        int nst = 0;
        int t;
        logic lv = 1'b0;
        logic lr = 1'b0;
        step_t.delete(); step_x.delete(); step_d.delete();
        qv_t.delete(); qv_q.delete(); qv_l.delete();
        n_done = 0; done_at = -1; err_first = -1; ir_bad = 0;
        @(negedge clk);
        start = 1'b1; in_valid = 1'b0; div_q_value = qpat[0];
        @(negedge clk);
        start = 1'b0;
        for (t = 0; t < 300; t++) begin
            if (t > 0) @(negedge clk);
            if (lv && lr) idx++;
            if (t == 0) err0 = err;
            if (div_step) begin
                step_t.push_back(t); step_x.push_back(div_x_value); step_d.push_back(div_d_value);
            end
            if (q_valid) begin
                qv_t.push_back(t); qv_q.push_back(q_out); qv_l.push_back(q_last);
            end
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = t;
            end
            if (err && err_first < 0) err_first = t;
            if (in_ready && idx >= N) ir_bad++;
            last_busy = busy;
            div_q_value = qpat[nst];
            if (div_step) nst++;
            div_error_flag = (t == err_rel);
            start = (t == busy_rel);
            if (idx < N) begin
                x_in = xs[idx];
                d_in = ds[idx];
                if (idx == stall_at && sl > 0 && in_ready) begin
                    in_valid = 1'b0;
                    sl--;
                end else begin
                    in_valid = 1'b1;
                end
            end else begin
                in_valid = 1'b0;
            end
            lv = in_valid;
            lr = in_ready;
            if (t == stop_at) break;
            if (done_at >= 0 && t == done_at + 2) break;
        end
        div_error_flag = 1'b0;
        in_valid = 1'b0;
        if (stop_at < 0) begin
            checks++;
            if (done_at < 0) begin
                failures++;
                $display("FAIL timeout: no done within %0d cycles, required a done pulse", t);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; x_in = '0; d_in = '0;
        div_q_value = '0; div_error_flag = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, div_step, q_valid, q_last, busy, done, err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags: got=%b required=0000000",
                     {in_ready, div_step, q_valid, q_last, busy, done, err});
        end
        checks++;
        if ({div_x_value, div_d_value, q_out} !== 6'b0) begin
            failures++;
            $display("FAIL reset_values: got=%b required=000000", {div_x_value, div_d_value, q_out});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        xs = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
        ds = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        for (int i = 0; i < 16; i++) qpat[i] = (i % 3 == 0) ? 2'b10 : (i % 3 == 1) ? 2'b01 : 2'b00;
        run_op(-1, 0, -1, -1, -1);
        checks++;
        if (step_t.size() != NS) begin
            failures++; $display("FAIL basic_steps: got=%0d required=%0d", step_t.size(), NS);
        end
        for (int k = 1; k <= step_t.size() && k <= NS; k++) begin
            checks++;
            if (step_t[k-1] != exp_step(k, -1, 0)) begin
                failures++;
                $display("FAIL basic_step_time k=%0d: got=%0d required=%0d", k, step_t[k-1], exp_step(k, -1, 0));
            end
        end
        checks++;
        if (qv_t.size() != N) begin
            failures++; $display("FAIL basic_qcount: got=%0d required=%0d", qv_t.size(), N);
        end
        for (int i = 0; i < qv_t.size() && i < N; i++) begin
            checks++;
            if (qv_q[i] !== qpat[DL+i] || qv_t[i] != exp_step(DL+1+i, -1, 0) + 1 || qv_l[i] !== (i == N-1)) begin
                failures++;
                $display("FAIL basic_q i=%0d: got q=%b t=%0d last=%b required q=%b t=%0d last=%b", i, qv_q[i],
                         qv_t[i], qv_l[i], qpat[DL+i], exp_step(DL+1+i, -1, 0) + 1, i == N-1);
            end
        end
        checks++;
        if (n_done != 1 || done_at != exp_step(NS, -1, 0) + 2 || last_busy !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL basic_done: got n=%0d t=%0d busy=%b err=%b required n=1 t=%0d busy=0 err=0",
                     n_done, done_at, last_busy, err, exp_step(NS, -1, 0) + 2);
        end
    endtask

    task automatic test_stall();
        int n9 = 0;
        rand_data();
        run_op(3, 5, -1, -1, -1);
        for (int k = 2; k <= step_t.size(); k++) if (step_t[k-1] - step_t[k-2] == 9) n9++;
        checks++;
        if (step_t.size() != NS || n9 != 1) begin
            failures++; $display("FAIL stall_spacing: got steps=%0d gaps9=%0d required %0d and 1", step_t.size(), n9, NS);
        end
        for (int i = 0; i < qv_q.size() && i < N; i++) begin
            checks++;
            if (qv_q[i] !== qpat[DL+i]) begin
                failures++; $display("FAIL stall_q i=%0d: got=%b required=%b", i, qv_q[i], qpat[DL+i]);
            end
        end
        checks++;
        if (qv_q.size() != N || done_at != exp_step(NS, -1, 0) + 2 + 5) begin
            failures++; $display("FAIL stall_total: got q=%0d done=%0d required q=%0d done=%0d",
                                 qv_q.size(), done_at, N, exp_step(NS, -1, 0) + 7);
        end
`ifdef ONLINE_DIV_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'd5) begin
            failures++; $display("FAIL stall_cnt: got=%0d required=5", stall_cnt);
        end
`endif
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int a = $urandom_range(0, N-1);
            int len = $urandom_range(0, 6);
            rand_data();
            run_op(a, len, -1, -1, -1);
            checks++;
            if (step_t.size() != NS || qv_q.size() != N || ir_bad != 0) begin
                failures++; $display("FAIL rand_counts it=%0d: got steps=%0d q=%0d ready_late=%0d required %0d %0d 0",
                                     it, step_t.size(), qv_q.size(), ir_bad, NS, N);
            end
            for (int k = 1; k <= step_t.size() && k <= NS; k++) begin
                checks++;
                if (step_t[k-1] != exp_step(k, a, len) || step_x[k-1] !== exp_x(k) || step_d[k-1] !== exp_d(k)) begin
                    failures++;
                    $display("FAIL rand_step it=%0d k=%0d: got t=%0d x=%b d=%b required t=%0d x=%b d=%b", it, k,
                             step_t[k-1], step_x[k-1], step_d[k-1], exp_step(k, a, len), exp_x(k), exp_d(k));
                end
            end
            for (int i = 0; i < qv_q.size() && i < N; i++) begin
                checks++;
                if (qv_q[i] !== qpat[DL+i] || qv_l[i] !== (i == N-1)) begin
                    failures++; $display("FAIL rand_q it=%0d i=%0d: got=%b/%b required=%b/%b", it, i,
                                         qv_q[i], qv_l[i], qpat[DL+i], i == N-1);
                end
            end
            checks++;
            if (done_at != exp_step(NS, a, len) + 2) begin
                failures++; $display("FAIL rand_done it=%0d: got=%0d required=%0d", it, done_at, exp_step(NS, a, len) + 2);
            end
`ifdef ONLINE_DIV_STALL_CNT_EN
            checks++;
            if (stall_cnt !== 16'(len)) begin
                failures++; $display("FAIL rand_stall_cnt it=%0d: got=%0d required=%0d", it, stall_cnt, len);
            end
`endif
        end
    endtask

    task automatic test_illegal();
        rand_data();
        xs[2] = 2'b11; ds[5] = 2'b11; xs[6] = 2'b01;
        run_op(-1, 0, -1, -1, -1);
        checks++;
        if (step_x.size() < 7 || step_x[2] !== 2'b00 || step_d[5] !== 2'b00 || step_x[6] !== 2'b01) begin
            failures++; $display("FAIL illegal_digit: got x3=%b d6=%b x7=%b required 00 00 01",
                                 step_x.size() > 2 ? step_x[2] : 2'bxx, step_d.size() > 5 ? step_d[5] : 2'bxx,
                                 step_x.size() > 6 ? step_x[6] : 2'bxx);
        end
    endtask

    task automatic test_error();
        rand_data();
        run_op(-1, 0, 17, -1, -1);
        checks++;
        if (err_first != 18 || n_done != 1 || done_at != 18) begin
            failures++; $display("FAIL error_timing: got err_t=%0d n_done=%0d done_t=%0d required 18 1 18",
                                 err_first, n_done, done_at);
        end
        checks++;
        if (qv_t.size() != 1 || step_t.size() != 4) begin
            failures++; $display("FAIL error_suppress: got q=%0d steps=%0d required 1 4", qv_t.size(), step_t.size());
        end
        checks++;
        if (err !== 1'b1) begin
            failures++; $display("FAIL error_sticky: got=%b required=1", err);
        end
        rand_data();
        run_op(-1, 0, -1, -1, -1);
        checks++;
        if (err0 !== 1'b0 || err !== 1'b0 || qv_t.size() != N) begin
            failures++; $display("FAIL error_clear: got err0=%b err=%b q=%0d required 0 0 %0d", err0, err, qv_t.size(), N);
        end
    endtask

    task automatic test_error_final();
        rand_data();
        run_op(-1, 0, exp_step(NS, -1, 0), -1, -1);
        checks++;
        if (qv_t.size() != N || (qv_t.size() == N && qv_l[N-1] !== 1'b1) || err_first != exp_step(NS, -1, 0) + 1 ||
            done_at != exp_step(NS, -1, 0) + 1 || n_done != 1) begin
            failures++; $display("FAIL error_final: got q=%0d err_t=%0d done_t=%0d n_done=%0d required %0d %0d %0d 1",
                                 qv_t.size(), err_first, done_at, n_done, N, exp_step(NS, -1, 0) + 1,
                                 exp_step(NS, -1, 0) + 1);
        end
    endtask

    task automatic test_start_busy();
        rand_data();
        run_op(-1, 0, -1, 20, -1);
        checks++;
        if (step_t.size() != NS || qv_q.size() != N || done_at != exp_step(NS, -1, 0) + 2 || n_done != 1) begin
            failures++; $display("FAIL start_busy: got steps=%0d q=%0d done=%0d required %0d %0d %0d",
                                 step_t.size(), qv_q.size(), done_at, NS, N, exp_step(NS, -1, 0) + 2);
        end
        for (int i = 0; i < qv_q.size() && i < N; i++) begin
            checks++;
            if (qv_q[i] !== qpat[DL+i]) begin
                failures++; $display("FAIL start_busy_q i=%0d: got=%b required=%b", i, qv_q[i], qpat[DL+i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        rand_data();
        qpat[DL] = 2'b10;
        run_op(-1, 0, -1, -1, 22);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, div_step, q_valid, q_last, busy, done, err, div_x_value, div_d_value, q_out} !== 13'b0) begin
            failures++; $display("FAIL reset_mid: got=%b required all zero",
                                 {in_ready, div_step, q_valid, q_last, busy, done, err, div_x_value, div_d_value, q_out});
        end
        @(negedge clk);
        rst_n = 1'b1;
        rand_data();
        run_op(-1, 0, -1, -1, -1);
        checks++;
        if (qv_q.size() != N || done_at != exp_step(NS, -1, 0) + 2) begin
            failures++; $display("FAIL reset_rerun: got q=%0d done=%0d required %0d %0d",
                                 qv_q.size(), done_at, N, exp_step(NS, -1, 0) + 2);
        end
        for (int i = 0; i < qv_q.size() && i < N; i++) begin
            checks++;
            if (qv_q[i] !== qpat[DL+i]) begin
                failures++; $display("FAIL reset_rerun_q i=%0d: got=%b required=%b", i, qv_q[i], qpat[DL+i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_random();
        test_illegal();
        test_error();
        test_error_final();
        test_start_busy();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
